slice_line_assembler: RTL and testbench

- Serial-to-parallel writer for the 25-bit lane memory.
- Accepts a stream of single bits over a valid/ready handshake and assembles them into one 25-bit line, using the same index mapping the lane memory uses: stream index k lands at bit MEMSIZE-1-k.
- Presents each completed line, with 5x5 coordinate tracking, on a valid/ready output.
- The line output feeds the lane memory's `line`/`init` load path.

---
 rtl/slice_line_assembler_if.sv | 29 ++
 rtl/slice_line_assembler.sv | 96 +++++++++
 tb/tb_slice_line_assembler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/slice_line_assembler_if.sv
// Handshake bundle between the serial bit source, the line assembler and the
// lane-memory loader.
interface slice_line_assembler_if #(
  parameter int MEMSIZE = 25,
  parameter int IDXW    = 5
);
  logic               start;
  logic               abort;
  logic               bit_in;
  logic               bit_valid;
  logic               bit_ready;
  logic [IDXW-1:0]    index;
  logic [2:0]         col;
  logic [2:0]         row;
  logic [MEMSIZE-1:0] line;
  logic               line_valid;
  logic               line_ready;
  logic [7:0]         line_count;

  modport slave (
    input  start, abort, bit_in, bit_valid, line_ready,
    output bit_ready, index, col, row, line, line_valid, line_count
  );

  modport master (
    output start, abort, bit_in, bit_valid, line_ready,
    input  bit_ready, index, col, row, line, line_valid, line_count
  );
endinterface

// File: rtl/slice_line_assembler.sv
// Serial-to-parallel line writer: packs a bit stream into one lane-memory line
// (stream index k -> bit MEMSIZE-1-k) and offers it on a valid/ready output.
module slice_line_assembler #(
  parameter int MEMSIZE = 25,
  parameter int ROWS    = 5,
  parameter int COLS    = 5,
  parameter int IDXW    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  slice_line_assembler_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(MEMSIZE - 1);

  state_t             r_state;
  logic               r_bit_ready;
  logic               r_line_valid;
  logic [IDXW-1:0]    r_index;
  logic [2:0]         r_col;
  logic [2:0]         r_row;
  logic [MEMSIZE-1:0] r_line;
  logic [7:0]         r_line_count;

  logic [IDXW-1:0]    w_pos;
  logic               w_col_wrap;

  assign w_pos      = LAST - r_index;
  assign w_col_wrap = (r_col == 3'(COLS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bit_ready  <= 1'b0;
      r_line_valid <= 1'b0;
      r_index      <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_line       <= '0;
      r_line_count <= '0;
    end else if (bus.abort) begin
      r_state      <= IDLE;
      r_bit_ready  <= 1'b0;
      r_line_valid <= 1'b0;
      r_index      <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_line       <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_state     <= COLLECT;
          r_bit_ready <= 1'b1;
        end
        COLLECT: if (bus.bit_valid) begin
          r_line[w_pos] <= bus.bit_in;
          if (r_index == LAST) begin
            // Coordinates rewind on completion so they already describe the next line.
            r_state      <= HOLD;
            r_bit_ready  <= 1'b0;
            r_line_valid <= 1'b1;
            r_index      <= '0;
            r_col        <= '0;
            r_row        <= '0;
          end else begin
            r_index <= r_index + IDXW'(1);
            r_col   <= w_col_wrap ? 3'd0 : r_col + 3'd1;
            if (w_col_wrap)
              r_row <= (r_row == 3'(ROWS - 1)) ? 3'd0 : r_row + 3'd1;
          end
        end
        HOLD: if (bus.line_ready) begin
          r_state      <= COLLECT;
          r_bit_ready  <= 1'b1;
          r_line_valid <= 1'b0;
          r_line       <= '0;
          r_line_count <= r_line_count + 8'd1;
        end
        default: begin
          r_state      <= IDLE;
          r_bit_ready  <= 1'b0;
          r_line_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bit_ready  = r_bit_ready;
  assign bus.line_valid = r_line_valid;
  assign bus.index      = r_index;
  assign bus.col        = r_col;
  assign bus.row        = r_row;
  assign bus.line       = r_line;
  assign bus.line_count = r_line_count;
endmodule

// File: tb/tb_slice_line_assembler.sv
// Directed bench for slice_line_assembler: mapping, coordinates, back-pressure,
// gaps, abort, count wrap and asynchronous reset.
module tb_slice_line_assembler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [24:0] pat;
  logic [24:0] held;

  always #5 clk = ~clk;

  slice_line_assembler_if #(.MEMSIZE(25), .IDXW(5)) bus ();

  slice_line_assembler #(.MEMSIZE(25), .ROWS(5), .COLS(5), .IDXW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feed stream indices k0..k1 of p, with 0..gapmax idle cycles before each bit.
  task automatic send_bits(input logic [24:0] p, input int k0, input int k1, input int gapmax);
    for (int k = k0; k <= k1; k++) begin
      int gaps;
      gaps = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      bus.bit_valid = 1'b0;
      for (int g = 0; g < gaps; g++) step();
      bus.bit_valid = 1'b1;
      bus.bit_in    = p[24-k];
      chk("index", 32'(bus.index), 32'(k));
      chk("row", 32'(bus.row), 32'(k / 5));
      chk("col", 32'(bus.col), 32'(k % 5));
      chk("bit_ready_collect", 32'(bus.bit_ready), 32'd1);
      step();
    end
    bus.bit_valid = 1'b0;
  endtask

  // In HOLD: check the line, then take it with line_ready=1.
  task automatic finish_line(input logic [24:0] p);
    chk("hold_valid", 32'(bus.line_valid), 32'd1);
    chk("hold_line", 32'(bus.line), 32'(p));
    chk("hold_bit_ready", 32'(bus.bit_ready), 32'd0);
    chk("hold_index", 32'(bus.index), 32'd0);
    bus.line_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + 8'd1;
    chk("post_valid", 32'(bus.line_valid), 32'd0);
    chk("post_bit_ready", 32'(bus.bit_ready), 32'd1);
    chk("post_count", 32'(bus.line_count), 32'(exp_cnt));
    chk("post_line", 32'(bus.line), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0; bus.line_ready = 1'b1;

    // Reset state and start latency
    #2;
    chk("rst_bit_ready", 32'(bus.bit_ready), 32'd0);
    chk("rst_valid", 32'(bus.line_valid), 32'd0);
    chk("rst_line", 32'(bus.line), 32'd0);
    chk("rst_index", 32'(bus.index), 32'd0);
    chk("rst_count", 32'(bus.line_count), 32'd0);
    step(); rst = 1'b0;
    step();
    chk("idle_bit_ready", 32'(bus.bit_ready), 32'd0);
    bus.start = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
    step();
    bus.start = 1'b0; bus.bit_valid = 1'b0;
    chk("start_bit_ready", 32'(bus.bit_ready), 32'd1);
    chk("start_no_accept", 32'(bus.index), 32'd0);

    // Mapping: first and last bits set
    send_bits(25'h1000001, 0, 24, 0);
    finish_line(25'h1000001);

    // Single bit at k=7 lands at bit 17
    send_bits(25'h0020000, 0, 24, 0);
    finish_line(25'h0020000);

    // Back-pressure for 10 cycles while bit_valid stays high
    bus.line_ready = 1'b0;
    send_bits(25'h155AA33, 0, 24, 0);
    bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_line", 32'(bus.line), 32'h155AA33);
      chk("bp_bit_ready", 32'(bus.bit_ready), 32'd0);
      chk("bp_index", 32'(bus.index), 32'd0);
      chk("bp_valid", 32'(bus.line_valid), 32'd1);
    end
    bus.line_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + 8'd1;
    chk("bp_count", 32'(bus.line_count), 32'(exp_cnt));
    chk("bp_index_after", 32'(bus.index), 32'd0);
    step();
    bus.bit_valid = 1'b0;
    chk("bp_next_accept", 32'(bus.index), 32'd1);
    chk("bp_next_line", 32'(bus.line), 32'h1000000);

    // Start in COLLECT is ignored; then abort at index 12 with a bit offered
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_ignored", 32'(bus.index), 32'd1);
    send_bits(25'h1FFFFFF, 1, 11, 0);
    chk("pre_abort_index", 32'(bus.index), 32'd12);
    bus.abort = 1'b1; bus.bit_valid = 1'b1; bus.line_ready = 1'b1;
    step();
    bus.abort = 1'b0; bus.bit_valid = 1'b0;
    chk("abort_index", 32'(bus.index), 32'd0);
    chk("abort_line", 32'(bus.line), 32'd0);
    chk("abort_bit_ready", 32'(bus.bit_ready), 32'd0);
    chk("abort_count", 32'(bus.line_count), 32'(exp_cnt));
    step();
    chk("abort_idle_hold", 32'(bus.bit_ready), 32'd0);

    // Gapped input over three lines
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    send_bits(25'h0ABCDEF, 0, 24, 3); finish_line(25'h0ABCDEF);
    send_bits(25'h1234567, 0, 24, 3); finish_line(25'h1234567);
    send_bits(25'h18C6318, 0, 24, 3); finish_line(25'h18C6318);
    chk("gap_count", 32'(bus.line_count), 32'd6);

    // Count wrap after 256 completed lines
    for (int n = 6; n < 256; n++) begin
      pat = 25'($urandom);
      send_bits(pat, 0, 24, 0);
      finish_line(pat);
    end
    chk("wrap_count", 32'(bus.line_count), 32'd0);

    // Asynchronous reset in HOLD
    bus.line_ready = 1'b0;
    held = 25'h0F0F0F0;
    send_bits(held, 0, 24, 0);
    chk("pre_rst_valid", 32'(bus.line_valid), 32'd1);
    chk("pre_rst_count", 32'(bus.line_count), 32'd0);
    step(); step();
    chk("pre_rst_count2", 32'(bus.line_count), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.line_valid), 32'd0);
    chk("arst_line", 32'(bus.line), 32'd0);
    chk("arst_bit_ready", 32'(bus.bit_ready), 32'd0);
    chk("arst_index", 32'(bus.index), 32'd0);
    step();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
